rcvfifo: RTL and testbench

Parametrised serial-line receiver with an integrated receive FIFO. It is the successor to the single-entry receive buffer. It deserialises asynchronous 8N1-style frames of configurable data width and queues up to DEPTH words. It reports queue occupancy, sticky overrun, and framing-error status to the CPU-side I/O register interface.

---
 rtl/rcvfifo.sv | 178 +++++++++++++++++
 tb/tb_rcvfifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcvfifo.sv
// Serial-line receiver (start bit, DATA_BITS data bits LSB first, one stop bit) feeding a
// show-ahead receive FIFO, with sticky overrun and framing-error status for the CPU side.
module rcvfifo #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 read,
    input  logic                 clr_err,
    output logic                 ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic [ADDR_W:0]      count,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0]   HALF_LOAD = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0]   FULL_LOAD = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rxState_t;

    logic                 sync1_q, sync2_q;
    logic                 line;
    rxState_t             state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push_q, push_d;
    logic                 frameErr_q, frameErr_d;
    logic                 overrun_q, overrun_d;
    logic                 ferrSet;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 doPush, doPop, ovSet;

    // Two-flop synchroniser, preset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        push_d   = 1'b0;
        ferrSet  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!line) begin
                    state_d = START;
                    timer_d = HALF_LOAD;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    if (!line) begin
                        state_d  = DATA;
                        bitIdx_d = '0;
                        timer_d  = FULL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    timer_d = FULL_LOAD;
                    if (bitIdx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + BW'(1);
                    end
                end
            end
            STOP: begin
                // Returning to IDLE mid-stop-bit lets the next start edge be caught early.
                if (timer_q == '0) begin
                    if (line) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferrSet = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (line) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push that finds the FIFO full is only dropped if no pop frees a slot in the same cycle.
    always_comb begin
        doPop     = read && (count_q != '0);
        doPush    = push_q && ((count_q != FULL_CNT) || doPop);
        ovSet     = push_q && !doPush;
        wrPtr_d   = doPush ? wrPtr_q + ADDR_W'(1) : wrPtr_q;
        rdPtr_d   = doPop ? rdPtr_q + ADDR_W'(1) : rdPtr_q;
        count_d   = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end
        frameErr_d = ferrSet ? 1'b1 : (clr_err ? 1'b0 : frameErr_q);
        overrun_d  = ovSet ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= shift_q;
        end
    end

    assign ready     = (count_q != '0);
    assign data_out  = ready ? mem_q[rdPtr_q] : '0;
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_rcvfifo.sv
// Self-checking bench for rcvfifo: frame-level queue model, a small vector table,
// directed corner-case sequences and randomized frames with pops around the push edge.
module tb_rcvfifo;

    localparam int C         = 16;
    localparam int DB        = 8;
    localparam int DEPTH     = 16;
    localparam int AW        = 4;
    localparam int FRAME_LEN = (DB + 2) * C;
    // Stop-bit middle is on the wire at edge (DB+1)*C + C/2; the receiver sees it one edge
    // later through the synchroniser, and ready/count follow 2 clk after that sample.
    localparam int PUSH_EDGE = (DB + 1) * C + C / 2 + 3;
    // A framing error is flagged one clk after the stop-bit sample.
    localparam int ERR_EDGE  = PUSH_EDGE - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          serial_in = 1'b1;
    logic          read = 1'b0;
    logic          clr_err = 1'b0;
    logic          ready;
    logic [DB-1:0] data_out;
    logic [AW:0]   count;
    logic          overrun;
    logic          frame_err;

    rcvfifo #(
        .CLK_DIV  (C),
        .DATA_BITS(DB),
        .DEPTH    (DEPTH),
        .ADDR_W   (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .serial_in(serial_in),
        .read     (read),
        .clr_err  (clr_err),
        .ready    (ready),
        .data_out (data_out),
        .count    (count),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DB-1:0] modelQ[$];
    bit            modelOv = 0;
    bit            modelFe = 0;
    int            pushEdge;

    typedef struct {
        logic [DB-1:0] data;
        bit            stopOk;
        int            expCount;
        bit            expFe;
        logic [DB-1:0] expHead;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        cmp({name, " ready"}, int'(ready), int'(modelQ.size() != 0));
        cmp({name, " count"}, int'(count), modelQ.size());
        cmp({name, " data_out"}, int'(data_out), (modelQ.size() != 0) ? int'(modelQ[0]) : 0);
        cmp({name, " overrun"}, int'(overrun), int'(modelOv));
        cmp({name, " frame_err"}, int'(frame_err), int'(modelFe));
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        serial_in = 1'b1;
        read      = 1'b0;
        clr_err   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        modelQ.delete();
        modelOv = 0;
        modelFe = 0;
        checkOutput("reset");
    endtask

    task automatic pulseClr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        modelOv = 0;
        modelFe = 0;
    endtask

    task automatic popWord(input string name);
        if (modelQ.size() != 0) begin
            cmp({name, " popped"}, int'(data_out), int'(modelQ[0]));
            void'(modelQ.pop_front());
        end
        read = 1'b1;
        tick();
        read = 1'b0;
        checkOutput(name);
    endtask

    // One frame, then holdLow cycles of low line and gap cycles of idle. read/clr_err are
    // pulsed in the cycle numbered popAt/clrAt (edge index from the start bit, -1 = none).
    // clrAt is only meant for frames with a bad stop bit.
    task automatic applyStimulus(input logic [DB-1:0] data, input bit stopOk, input int popAt,
                                 input int clrAt, input int holdLow, input int gap);
        int            total = FRAME_LEN + holdLow + gap;
        int            prevCount;
        logic [DB-1:0] popSeen = '0;
        pushEdge  = -1;
        prevCount = int'(count);
        for (int t = 0; t < total; t++) begin
            if (t < C) serial_in = 1'b0;
            else if (t < (DB + 1) * C) serial_in = data[t/C-1];
            else if (t < FRAME_LEN) serial_in = stopOk;
            else if (t < FRAME_LEN + holdLow) serial_in = 1'b0;
            else serial_in = 1'b1;
            read    = (t == popAt);
            clr_err = (t == clrAt);
            if (read) popSeen = data_out;
            tick();
            if (pushEdge < 0 && int'(count) > prevCount) pushEdge = t;
            prevCount = int'(count);
        end
        read      = 1'b0;
        clr_err   = 1'b0;
        serial_in = 1'b1;
        if (popAt >= 0 && popAt <= PUSH_EDGE && modelQ.size() != 0) begin
            cmp("frame pop", int'(popSeen), int'(modelQ[0]));
            void'(modelQ.pop_front());
        end
        if (stopOk) begin
            if (modelQ.size() < DEPTH) modelQ.push_back(data);
            else modelOv = 1;
        end else begin
            if (clrAt >= 0) modelOv = 0;
            modelFe = (clrAt > ERR_EDGE) ? 0 : 1;
        end
        if (popAt > PUSH_EDGE && popAt < total && modelQ.size() != 0) begin
            cmp("frame pop", int'(popSeen), int'(modelQ[0]));
            void'(modelQ.pop_front());
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DB-1:0] d;
        bit            ok;
        int            popAt;
        int            gap;

        vecs[0] = '{8'h11, 1'b1, 1, 1'b0, 8'h11};
        vecs[1] = '{8'h22, 1'b0, 1, 1'b1, 8'h11};
        vecs[2] = '{8'h33, 1'b1, 2, 1'b1, 8'h11};
        vecs[3] = '{8'hFE, 1'b1, 3, 1'b1, 8'h11};

        $display("[TB] basic frame");
        applyReset();
        applyStimulus(8'hA5, 1'b1, -1, -1, 0, 0);
        cmp("t1 push edge", pushEdge, PUSH_EDGE);
        cmp("t1 head", int'(data_out), 'hA5);
        checkOutput("t1");
        popWord("t1 pop");

        $display("[TB] vector table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stopOk, -1, -1, 0, C);
            cmp("vec count", int'(count), vecs[i].expCount);
            cmp("vec frame_err", int'(frame_err), int'(vecs[i].expFe));
            cmp("vec head", int'(data_out), int'(vecs[i].expHead));
            checkOutput("vec");
        end
        repeat (3) popWord("vec drain");
        pulseClr();
        checkOutput("vec clr");

        $display("[TB] back-to-back and overrun");
        for (int i = 0; i <= DEPTH; i++) applyStimulus(8'(i), 1'b1, -1, -1, 0, 0);
        cmp("t2 count", int'(count), DEPTH);
        cmp("t2 overrun", int'(overrun), 1);
        checkOutput("t2 full");
        repeat (DEPTH) popWord("t2 drain");
        popWord("t2 read empty");
        pulseClr();
        checkOutput("t2 clr");

        $display("[TB] framing error and break");
        applyReset();
        applyStimulus(8'h3C, 1'b0, -1, ERR_EDGE, 40 * C, C);
        cmp("t3 frame_err set wins", int'(frame_err), 1);
        checkOutput("t3 break");
        applyStimulus(8'h81, 1'b1, -1, -1, 0, 0);
        cmp("t3 head", int'(data_out), 'h81);
        checkOutput("t3 after break");
        pulseClr();
        checkOutput("t3 clr");
        popWord("t3 pop");

        $display("[TB] false start");
        serial_in = 1'b0;
        repeat (C / 4) tick();
        serial_in = 1'b1;
        repeat (2 * C) tick();
        checkOutput("t4 glitch");
        applyStimulus(8'h42, 1'b1, -1, -1, 0, 0);
        checkOutput("t4 next frame");
        popWord("t4 pop");

        $display("[TB] full with simultaneous pop");
        for (int i = 0; i < DEPTH; i++) applyStimulus(8'(8'hC0 + i), 1'b1, -1, -1, 0, 0);
        applyStimulus(8'h77, 1'b1, PUSH_EDGE, -1, 0, 0);
        cmp("t5 count", int'(count), DEPTH);
        cmp("t5 overrun", int'(overrun), 0);
        checkOutput("t5 full");
        repeat (DEPTH - 1) popWord("t5 drain");
        cmp("t5 last", int'(data_out), 'h77);
        popWord("t5 final");

        $display("[TB] reset mid-frame");
        applyReset();
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h10 + i), 1'b1, -1, -1, 0, 0);
        checkOutput("t6 queued");
        d = 8'hE7;
        for (int t = 0; t < 4 * C + 8; t++) begin
            serial_in = (t < C) ? 1'b0 : d[t/C-1];
            tick();
        end
        reset     = 1'b1;
        serial_in = 1'b1;
        tick();
        modelQ.delete();
        modelOv = 0;
        modelFe = 0;
        checkOutput("t6 in reset");
        reset = 1'b0;
        applyStimulus(8'h5A, 1'b1, -1, -1, 0, 0);
        cmp("t6 head", int'(data_out), 'h5A);
        checkOutput("t6 after");

        $display("[TB] random frames");
        applyReset();
        for (int n = 0; n < 48; n++) begin
            d     = 8'($urandom);
            ok    = ($urandom_range(0, 7) != 0);
            popAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, FRAME_LEN - 1)) : -1;
            gap   = (ok && $urandom_range(0, 1) == 0) ? 0 : C;
            applyStimulus(d, ok, popAt, -1, 0, gap);
            checkOutput("rand frame");
            if ($urandom_range(0, 7) == 0) begin
                pulseClr();
                checkOutput("rand clr");
            end
            if ($urandom_range(0, 3) == 0) popWord("rand pop");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
